// File: rtl/pulse_mon_pkg.sv
// Shared state encoding and widths for the pulse-width monitor.
package pulse_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam int ERR_W = 8;

  // Width needed to count closed runs from 0 up to and including n.
  function automatic int run_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pulse_width_monitor_sat_counter.sv
// Saturating up-counter with clear-to-0 and load-to-1; used for run length and error count.
// One-cycle update; clear beats load beats increment, and the count holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] MAX_CNT = '1;

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= W'(1);
    end else if (i_inc && (r_cnt != MAX_CNT)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pulse_width_monitor.sv
// Measures constant-level run lengths on din and checks each against EXP_LEN +/- TOL.
// A run closed by the sample in cycle k is reported in cycle k+1; done/pass follow the last closure.
module pulse_width_monitor
  import pulse_mon_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int EXP_LEN  = 20,
  parameter int TOL      = 0,
  parameter int NUM_RUNS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             start,
  input  logic             stop,
  output logic             run_valid,
  output logic [CNT_W-1:0] run_len,
  output logic             run_level,
  output logic             run_ok,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
);

  localparam int                RUN_W    = run_cnt_w(NUM_RUNS);
  localparam logic [RUN_W-1:0]  LAST_RUN = RUN_W'(NUM_RUNS - 1);
  localparam logic [RUN_W-1:0]  ALL_RUNS = RUN_W'(NUM_RUNS);
  localparam logic [CNT_W:0]    EXP_EXT  = (CNT_W + 1)'(EXP_LEN);
  localparam logic [CNT_W:0]    TOL_EXT  = (CNT_W + 1)'(TOL);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_level;
  logic [RUN_W-1:0]  r_runs;
  logic              r_run_valid;
  logic [CNT_W-1:0]  r_run_len;
  logic              r_run_level;
  logic              r_run_ok;

  logic [CNT_W-1:0]  w_cnt;
  logic [ERR_W-1:0]  w_err;
  logic              w_meas;
  logic              w_arm;
  logic              w_toggle;
  logic              w_close;
  logic              w_last;
  logic              w_ok;
  logic [CNT_W:0]    w_cnt_ext;
  logic [CNT_W:0]    w_diff;

  assign w_meas   = (r_state == ST_MEASURE);
  assign w_arm    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  // stop wins over a level change, so the stop-cycle sample never starts a new run
  assign w_toggle = w_meas && !stop && (din != r_level);
  assign w_close  = w_meas && (stop || (din != r_level));
  assign w_last   = w_close && (r_runs == LAST_RUN);

  // One extra bit keeps the absolute difference from wrapping.
  assign w_cnt_ext = {1'b0, w_cnt};
  assign w_diff    = (w_cnt_ext >= EXP_EXT) ? (w_cnt_ext - EXP_EXT) : (EXP_EXT - w_cnt_ext);
  assign w_ok      = (w_diff <= TOL_EXT);

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (1'b0),
    .i_load (w_arm || w_toggle),
    .i_inc  (w_meas && !w_close),
    .o_cnt  (w_cnt)
  );

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_arm),
    .i_load (1'b0),
    .i_inc  (w_close && !w_ok),
    .o_cnt  (w_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_nxt = ST_MEASURE;
      ST_MEASURE: if (stop || w_last) w_state_nxt = ST_DONE;
      ST_DONE:    if (start) w_state_nxt = ST_MEASURE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (r_state)
      ST_MEASURE: busy = 1'b1;
      ST_DONE: begin
        done = 1'b1;
        pass = (r_runs == ALL_RUNS) && (w_err == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level     <= 1'b0;
      r_runs      <= '0;
      r_run_valid <= 1'b0;
      r_run_len   <= '0;
      r_run_level <= 1'b0;
      r_run_ok    <= 1'b0;
    end else begin
      r_run_valid <= w_close;
      if (w_arm) begin
        r_level <= din;
        r_runs  <= '0;
      end else if (w_close) begin
        r_run_len   <= w_cnt;
        r_run_level <= r_level;
        r_run_ok    <= w_ok;
        r_runs      <= r_runs + RUN_W'(1);
        if (!stop) begin
          r_level <= din;
        end
      end
    end
  end

  assign run_valid = r_run_valid;
  assign run_len   = r_run_len;
  assign run_level = r_run_level;
  assign run_ok    = r_run_ok;
  assign err_count = w_err;

endmodule

// File: tb/tb_pulse_width_monitor.sv
// Drives four differently-parameterised monitors from one waveform and checks
// every reported run against a run-length-encoding reference model.
module tb_pulse_width_monitor;

  localparam int NI = 4;
  localparam int CW  [NI] = '{8, 8, 4, 8};
  localparam int EXL [NI] = '{20, 20, 10, 1};
  localparam int TL  [NI] = '{0, 1, 0, 0};
  localparam int NR  [NI] = '{3, 3, 3, 3};

  typedef struct {
    int inst;
    int len;
    bit lvl;
    bit ok;
    bit dn;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst, din, start, stop;
  int   cyc = 0;

  logic [NI-1:0]      o_rv, o_lvl, o_ok, o_bsy, o_dn, o_ps;
  logic [NI-1:0][7:0] o_len, o_ec;

  ev_t  evq[$];
  ev_t  expq[$];
  ev_t  got[$];
  bit   smp[$];
  int   rl[$];
  int   t0;
  logic [NI-1:0] bsy0;
  bit   exp_pass;
  int   exp_err;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [CW[g]-1:0] len;
    logic [7:0]       ec;
    logic             rv, lvl, ok, bsy, dn, ps;

    pulse_width_monitor #(
      .CNT_W(CW[g]), .EXP_LEN(EXL[g]), .TOL(TL[g]), .NUM_RUNS(NR[g])
    ) u_dut (
      .clk(clk), .rst(rst), .din(din), .start(start), .stop(stop),
      .run_valid(rv), .run_len(len), .run_level(lvl), .run_ok(ok),
      .busy(bsy), .done(dn), .pass(ps), .err_count(ec)
    );

    assign o_rv[g]  = rv;
    assign o_lvl[g] = lvl;
    assign o_ok[g]  = ok;
    assign o_bsy[g] = bsy;
    assign o_dn[g]  = dn;
    assign o_ps[g]  = ps;
    assign o_ec[g]  = ec;
    assign o_len[g] = 8'(len);
  end

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (o_rv[g] === 1'b1)
        evq.push_back('{inst: g, len: int'(o_len[g]), lvl: o_lvl[g], ok: o_ok[g], dn: o_dn[g], cyc: cyc});
    end
  end

  task automatic build_smp(input bit lv0);
    bit lv;
    lv = lv0;
    smp.delete();
    foreach (rl[k]) begin
      repeat (rl[k]) smp.push_back(lv);
      lv = !lv;
    end
  endtask

  // Reference: split the first stp samples into constant-level runs, keep the first NUM_RUNS.
  task automatic build_expect(input int g, input int stp);
    int  st, en, len, d, errs, maxv;
    ev_t e;
    expq.delete();
    st = 0; errs = 0; maxv = (1 << CW[g]) - 1;
    while (st < stp && expq.size() < NR[g]) begin
      en = st;
      while (en < stp && smp[en] == smp[st]) en++;
      len = (en - st > maxv) ? maxv : en - st;
      d = len - EXL[g];
      if (d < 0) d = -d;
      e.inst = g; e.len = len; e.lvl = smp[st]; e.ok = (d <= TL[g]); e.dn = 1'b0;
      e.cyc = t0 + 1 + en;
      if (!e.ok) errs++;
      expq.push_back(e);
      st = en;
    end
    e = expq.pop_back();
    e.dn = 1'b1;
    expq.push_back(e);
    exp_pass = (expq.size() == NR[g]) && (errs == 0);
    exp_err  = (errs > 255) ? 255 : errs;
  endtask

  task automatic pick(input int g);
    got.delete();
    foreach (evq[k]) if (evq[k].inst == g) got.push_back(evq[k]);
  endtask

  // Sample index i is sampled by the edge numbered t0+1+i; start rides index 0, stop rides index stp.
  task automatic drive_seq(input int stp, input int st_lo, input int st_hi);
    evq.delete();
    @(negedge clk);
    t0 = cyc;
    for (int i = 0; i <= stp; i++) begin
      din   = (i < smp.size()) ? smp[i] : 1'b0;
      start = (i == 0) || (i >= st_lo && i <= st_hi);
      stop  = (i == stp);
      @(negedge clk);
      if (i == 0) bsy0 = o_bsy;
    end
    din = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    int n_before;
    rst = 1'b1; din = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      n_cmp++;
      if ({o_rv[g], o_lvl[g], o_ok[g], o_bsy[g], o_dn[g], o_ps[g], o_len[g], o_ec[g]} !== 22'd0) begin
        n_bad++;
        $display("FAIL reset_state inst%0d: rv=%b len=%0d lvl=%b ok=%b busy=%b done=%b pass=%b err=%0d, want all 0",
                 g, o_rv[g], o_len[g], o_lvl[g], o_ok[g], o_bsy[g], o_dn[g], o_ps[g], o_ec[g]);
      end
    end
    rst = 1'b0;
    rl = '{20, 20, 20, 1};
    build_smp(1'b0);
    for (int i = 0; i < 30; i++) begin
      din = smp[i]; start = (i == 0);
      @(negedge clk);
    end
    start = 1'b0; rst = 1'b1; din = smp[30];
    @(negedge clk);
    #1 n_before = evq.size();
    rst = 1'b0;
    for (int g = 0; g < NI; g++) begin
      n_cmp++;
      if ({o_rv[g], o_lvl[g], o_ok[g], o_bsy[g], o_dn[g], o_ps[g], o_len[g], o_ec[g]} !== 22'd0) begin
        n_bad++;
        $display("FAIL mid_reset inst%0d: rv=%b len=%0d busy=%b done=%b err=%0d, want all 0",
                 g, o_rv[g], o_len[g], o_bsy[g], o_dn[g], o_ec[g]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      din = i[0];
      @(negedge clk);
    end
    n_cmp++;
    if (evq.size() !== n_before) begin
      n_bad++;
      $display("FAIL reset_idle: %0d runs reported after reset, want 0", evq.size() - n_before);
    end
    drive_seq(smp.size(), -1, -1);
    for (int g = 0; g < NI; g++) begin
      build_expect(g, smp.size());
      pick(g);
      n_cmp++;
      if (got.size() == 0 || got[0].len !== expq[0].len || got[0].lvl !== expq[0].lvl || got[0].cyc !== expq[0].cyc) begin
        n_bad++;
        $display("FAIL rearm_first_run inst%0d: runs=%0d len=%0d cyc=%0d, want len=%0d cyc=%0d",
                 g, got.size(), (got.size() > 0) ? got[0].len : -1, (got.size() > 0) ? got[0].cyc - t0 : -1,
                 expq[0].len, expq[0].cyc - t0);
      end
    end
  endtask

  task automatic test_runs;
    int tbl [4][4] = '{'{20, 20, 20, 1}, '{20, 19, 20, 1}, '{20, 7, 0, 0}, '{30, 1, 0, 0}};
    for (int s = 0; s < 4; s++) begin
      rl.delete();
      for (int k = 0; k < 4; k++) if (tbl[s][k] > 0) rl.push_back(tbl[s][k]);
      build_smp(1'b0);
      drive_seq(smp.size(), -1, -1);
      for (int g = 0; g < NI; g++) begin
        build_expect(g, smp.size());
        pick(g);
        n_cmp++;
        if (got.size() !== expq.size()) begin
          n_bad++;
          $display("FAIL runs_count s%0d inst%0d: got %0d runs, want %0d", s, g, got.size(), expq.size());
        end
        for (int k = 0; k < got.size() && k < expq.size(); k++) begin
          n_cmp++;
          if (got[k].len !== expq[k].len || got[k].lvl !== expq[k].lvl || got[k].ok !== expq[k].ok ||
              got[k].dn !== expq[k].dn || got[k].cyc !== expq[k].cyc) begin
            n_bad++;
            $display("FAIL run s%0d inst%0d #%0d: len=%0d lvl=%b ok=%b done=%b at +%0d, want len=%0d lvl=%b ok=%b done=%b at +%0d",
                     s, g, k, got[k].len, got[k].lvl, got[k].ok, got[k].dn, got[k].cyc - t0,
                     expq[k].len, expq[k].lvl, expq[k].ok, expq[k].dn, expq[k].cyc - t0);
          end
        end
        n_cmp++;
        if (o_dn[g] !== 1'b1 || o_ps[g] !== exp_pass || o_ec[g] !== exp_err[7:0] || o_bsy[g] !== 1'b0 || bsy0[g] !== 1'b1) begin
          n_bad++;
          $display("FAIL final s%0d inst%0d: done=%b pass=%b err=%0d busy=%b busy_after_start=%b, want 1 %b %0d 0 1",
                   s, g, o_dn[g], o_ps[g], o_ec[g], o_bsy[g], bsy0[g], exp_pass, exp_err);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    smp = '{0, 1, 0, 1, 0, 1, 0, 1};
    drive_seq(8, 1, 2);
    for (int g = 0; g < NI; g++) begin
      pick(g);
      n_cmp++;
      if (got.size() !== 3) begin
        n_bad++;
        $display("FAIL b2b_count inst%0d: got %0d runs, want 3", g, got.size());
      end
      for (int k = 0; k < got.size() && k < 3; k++) begin
        n_cmp++;
        if (got[k].len !== 1 || got[k].lvl !== k[0] || got[k].cyc !== t0 + 2 + k) begin
          n_bad++;
          $display("FAIL b2b_run inst%0d #%0d: len=%0d lvl=%b at +%0d, want len=1 lvl=%b at +%0d",
                   g, k, got[k].len, got[k].lvl, got[k].cyc - t0, k[0], 2 + k);
        end
      end
      n_cmp++;
      if (o_dn[g] !== 1'b1 || o_ps[g] !== (g == 3) || o_ec[g] !== ((g == 3) ? 8'd0 : 8'd3)) begin
        n_bad++;
        $display("FAIL b2b_final inst%0d: done=%b pass=%b err=%0d, want 1 %b %0d",
                 g, o_dn[g], o_ps[g], o_ec[g], g == 3, (g == 3) ? 0 : 3);
      end
    end
  endtask

  task automatic test_random;
    int stp;
    for (int it = 0; it < 10; it++) begin
      rl.delete();
      repeat ($urandom_range(2, 5))
        rl.push_back(($urandom_range(0, 1) == 1) ? int'($urandom_range(19, 21)) : int'($urandom_range(1, 40)));
      build_smp(1'($urandom_range(0, 1)));
      stp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, smp.size())) : smp.size();
      drive_seq(stp, -1, -1);
      for (int g = 0; g < NI; g++) begin
        build_expect(g, stp);
        pick(g);
        n_cmp++;
        if (got.size() !== expq.size()) begin
          n_bad++;
          $display("FAIL rnd_count it%0d inst%0d: got %0d runs, want %0d", it, g, got.size(), expq.size());
        end
        for (int k = 0; k < got.size() && k < expq.size(); k++) begin
          n_cmp++;
          if (got[k].len !== expq[k].len || got[k].lvl !== expq[k].lvl || got[k].ok !== expq[k].ok ||
              got[k].dn !== expq[k].dn || got[k].cyc !== expq[k].cyc) begin
            n_bad++;
            $display("FAIL rnd_run it%0d inst%0d #%0d: len=%0d lvl=%b ok=%b done=%b at +%0d, want len=%0d lvl=%b ok=%b done=%b at +%0d",
                     it, g, k, got[k].len, got[k].lvl, got[k].ok, got[k].dn, got[k].cyc - t0,
                     expq[k].len, expq[k].lvl, expq[k].ok, expq[k].dn, expq[k].cyc - t0);
          end
        end
        n_cmp++;
        if (o_dn[g] !== 1'b1 || o_ps[g] !== exp_pass || o_ec[g] !== exp_err[7:0] || o_bsy[g] !== 1'b0) begin
          n_bad++;
          $display("FAIL rnd_final it%0d inst%0d: done=%b pass=%b err=%0d busy=%b, want 1 %b %0d 0",
                   it, g, o_dn[g], o_ps[g], o_ec[g], o_bsy[g], exp_pass, exp_err);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_runs();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_width_monitor.md
# pulse_width_monitor

Single-bit waveform checker: the observing end of the pulse-stimulus interface our benches drive (level held for a fixed number of cycles, then toggled). It samples a 1-bit line every clock, measures the length of each constant-level run, and compares each length against an expected value with tolerance. After a programmed number of runs it reports pass/fail. It sits in synthesizable self-test logic next to the stimulus source or DUT output it watches.

## Interface
- `CNT_W`, 8: run-length counter width; must satisfy EXP_LEN+TOL < 2^CNT_W−1.
- `EXP_LEN`, 20: expected run length in cycles.
- `TOL`, 0: accepted absolute deviation from EXP_LEN.
- `NUM_RUNS`, 3: runs to close before DONE.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  1  monitored line, sampled each rising edge.
- `start`  in  1  arms measurement; honoured in IDLE or DONE only.
- `stop`  in  1  closes current run and ends measurement; honoured in MEASURE only.
- `run_valid`  out  1  one-cycle pulse: a run just closed.
- `run_len`  out  CNT_W  length of closed run; valid with run_valid, held otherwise.
- `run_level`  out  1  level of closed run.
- `run_ok`  out  1  closed run within EXP_LEN±TOL.
- `busy`  out  1  high in MEASURE.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid while done: NUM_RUNS runs closed, zero errors.
- `err_count`  out  8  mismatched runs, saturates at 255.

## Operation
- States: IDLE, MEASURE, DONE.
- IDLE: start=1 → level←din, cnt←1, runs←0, err_count←0, go MEASURE.
- MEASURE, per cycle, priority order:
  - stop=1: close run with current cnt (stop-cycle din ignored), go DONE.
  - din≠level: close run with cnt; level←din, cnt←1.
  - else cnt←min(cnt+1, 2^CNT_W−1) (saturating).
- Close run: run_len←cnt, run_level←level, run_ok←(|cnt−EXP_LEN|≤TOL), run_valid←1; if !run_ok err_count saturating increment; runs←runs+1; if runs reaches NUM_RUNS, go DONE (the new run just started is discarded).
- A saturated cnt is compared as-is (normally mismatch).
- DONE: done=1, pass=(runs==NUM_RUNS && err_count==0). Stop before NUM_RUNS → pass=0. start re-arms exactly as from IDLE.
- start in MEASURE and stop outside MEASURE: ignored.
- Difference computed at CNT_W+1 bits, no wrap.

## Timing
- Reset value of every output: 0 (run_len 0, err_count 0, state IDLE). Reset mid-measurement aborts immediately, no run_valid.
- A run of N samples at one level, followed by a differing sample in cycle k, gives run_valid in cycle k+1 with run_len=N.
- Start cycle's din is sample 1 of run 1; busy rises the cycle after start.
- stop in cycle k → run_valid and done both high in cycle k+1.
- NUM_RUNS-th closure in cycle k → done high from k+1; busy low from k+1.
- run_valid never high two consecutive cycles unless din toggles every cycle (each run_len=1).

## Structure
- Shared package `pulse_mon_pkg`: state encoding constants (IDLE/MEASURE/DONE), err_count width (8).
- One sub-module: `sat_counter` (CNT_W-bit, load-to-1, saturating increment), used for cnt; err_count reuses it at width 8.
- Remaining FSM, comparator, output registers in the top module.

## Test plan
- EXP_LEN=20,TOL=0,NUM_RUNS=3: start with din=0, hold 0×20, 1×20, 0×20, then 1 → three run_valid, len 20/20/20, levels 0/1/0, run_ok=1, done, pass=1, err_count=0.
- Same but second run 1×19 → run 2 len 19, run_ok=0, err_count=1, pass=0; rerun with TOL=1 → pass=1.
- stop after run 1 and 7 cycles of run 2 → run_valid len 7, done next cycle, pass=0.
- CNT_W=4, EXP_LEN=10: hold 0×30 then toggle → run_len=15 (saturated), run_ok=0.
- rst asserted mid-run 2 → next cycle all outputs 0, IDLE; start re-arms cleanly and first run measures correctly.
- din toggling every cycle, NUM_RUNS=3, EXP_LEN=1 → run_valid three consecutive cycles, len 1 each, pass=1; start during MEASURE has no effect.
